sync_fifo_thr: RTL and testbench

Parametrised synchronous FIFO with valid/grant handshakes on both sides, for any depth (not only powers of two). Adds occupancy reporting, programmable almost-full/almost-empty flags, a high-water mark and a synchronous flush. Used between stream producers and consumers in the same clock domain; supersedes the fixed-function FIFO in new designs.

---
 rtl/sync_fifo_thr.sv | 130 +++++++++++++
 tb/tb_sync_fifo_thr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sync_fifo_thr: any-depth synchronous FIFO with occupancy, thresholds,   |
// | high-water mark and flush. Optional macro: SYNC_FIFO_BYPASS_EN.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sync_fifo_thr #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AFULL_THR  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THR = 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_grant_o,
  input  logic                  pop_grant_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  pop_valid_o,
  input  logic                  flush_i,
  output logic [CW-1:0]         occupancy_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CW-1:0]         hwm_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0] c_last_ptr = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_afull    = CW'(AFULL_THR);
  localparam logic [CW-1:0] c_aempty   = CW'(AEMPTY_THR);

  logic [DATA_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_hwm;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass_xfer;
  logic          w_wr;
  logic          w_rd;
  logic [PW-1:0] w_wp_next;
  logic [PW-1:0] w_rp_next;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_hwm_next;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_depth);

  // Full refuses a push even when a pop completes in the same cycle.
  assign push_grant_o = ~flush_i & ~w_full;

`ifdef SYNC_FIFO_BYPASS_EN
  logic w_bypass_sel;

  assign w_bypass_sel  = w_empty & ~flush_i;
  assign w_bypass_xfer = w_bypass_sel & push_valid_i & pop_grant_i;
  assign pop_valid_o   = w_bypass_sel ? push_valid_i : (~flush_i & ~w_empty);
  assign pop_data_o    = w_bypass_sel ? push_data_i  : r_mem[r_rp];
`else
  assign w_bypass_xfer = 1'b0;
  assign pop_valid_o   = ~flush_i & ~w_empty;
  assign pop_data_o    = r_mem[r_rp];
`endif

  assign w_push = push_valid_i & push_grant_o;
  assign w_pop  = pop_valid_o & pop_grant_i;

  // A bypassed word never touches storage, pointers or the count.
  assign w_wr = w_push & ~w_bypass_xfer;
  assign w_rd = w_pop & ~w_bypass_xfer;

  assign w_wp_next = (r_wp == c_last_ptr) ? '0 : r_wp + PW'(1);
  assign w_rp_next = (r_rp == c_last_ptr) ? '0 : r_rp + PW'(1);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_wr && !w_rd) begin
      w_cnt_next = r_cnt + CW'(1);
    end else if (w_rd && !w_wr) begin
      w_cnt_next = r_cnt - CW'(1);
    end
  end

  assign w_hwm_next = (w_cnt_next > r_hwm) ? w_cnt_next : r_hwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_hwm <= '0;
    end else if (flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_hwm <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= w_wp_next;
      end
      if (w_rd) begin
        r_rp <= w_rp_next;
      end
      r_cnt <= w_cnt_next;
      r_hwm <= w_hwm_next;
    end
  end

  // Storage is deliberately left unreset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= push_data_i;
    end
  end

  assign occupancy_o    = r_cnt;
  assign hwm_o          = r_hwm;
  assign almost_full_o  = (r_cnt >= c_afull);
  assign almost_empty_o = (r_cnt <= c_aempty);

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_thr.sv
`default_nettype none
// Directed self-checking bench for sync_fifo_thr (FIFO_DEPTH=5, AFULL_THR=4).
module tb_sync_fifo_thr;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] push_data;
  logic          push_valid;
  logic          push_grant;
  logic          pop_grant;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          flush;
  logic [CW-1:0] occupancy;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] hwm;

  int compared   = 0;
  int mismatched = 0;

  sync_fifo_thr #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .AFULL_THR (4),
    .AEMPTY_THR(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_data_i   (push_data),
    .push_valid_i  (push_valid),
    .push_grant_o  (push_grant),
    .pop_grant_i   (pop_grant),
    .pop_data_o    (pop_data),
    .pop_valid_o   (pop_valid),
    .flush_i       (flush),
    .occupancy_o   (occupancy),
    .almost_full_o (almost_full),
    .almost_empty_o(almost_empty),
    .hwm_o         (hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before checking.
  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pg, input logic fl);
    @(negedge clk);
    push_valid = pv;
    push_data  = pd;
    pop_grant  = pg;
    flush      = fl;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_grant  = 1'b0;
    flush      = 1'b0;

    // Reset state
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("rst_grant",  32'(push_grant),   32'd1);
    chk("rst_valid",  32'(pop_valid),    32'd0);
    chk("rst_occ",    32'(occupancy),    32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull",  32'(almost_full),  32'd0);
    chk("rst_hwm",    32'(hwm),          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x11..0x55 without popping
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'(8'h11 * (i + 1)), 0, 0);
      chk("fill_grant", 32'(push_grant),  32'd1);
      chk("fill_occ",   32'(occupancy),   32'(i));
      chk("fill_afull", 32'(almost_full), (i >= 4) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("fill_head", 32'(pop_data), 32'h11);
      end
    end
    drive(0, 8'h00, 0, 0);
    chk("full_grant",  32'(push_grant),   32'd0);
    chk("full_occ",    32'(occupancy),    32'd5);
    chk("full_afull",  32'(almost_full),  32'd1);
    chk("full_aempty", 32'(almost_empty), 32'd0);
    chk("full_hwm",    32'(hwm),          32'd5);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1, 0);
      chk("drain_valid",  32'(pop_valid),    32'd1);
      chk("drain_data",   32'(pop_data),     32'(8'h11 * (i + 1)));
      chk("drain_occ",    32'(occupancy),    32'(DEPTH - i));
      chk("drain_aempty", 32'(almost_empty), (DEPTH - i <= 1) ? 32'd1 : 32'd0);
    end
    drive(0, 8'h00, 0, 0);
    chk("empty_valid", 32'(pop_valid), 32'd0);
    chk("empty_occ",   32'(occupancy), 32'd0);
    chk("empty_hwm",   32'(hwm),       32'd5);

    // Streaming at occupancy 2: pointers wrap, order preserved
    drive(1, 8'hA0, 0, 0);
    drive(1, 8'hA1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(1, 8'(8'hA2 + i), 1, 0);
      chk("strm_occ",   32'(occupancy),  32'd2);
      chk("strm_grant", 32'(push_grant), 32'd1);
      chk("strm_data",  32'(pop_data),   32'(8'hA0 + i));
    end

    // Refill to full (holds AC, AD, B0, B1, B2)
    drive(1, 8'hB0, 0, 0);
    chk("refill_occ", 32'(occupancy), 32'd2);
    drive(1, 8'hB1, 0, 0);
    drive(1, 8'hB2, 0, 0);
    drive(1, 8'hFF, 1, 0);
    chk("fullpp_occ",   32'(occupancy),  32'd5);
    chk("fullpp_grant", 32'(push_grant), 32'd0);
    chk("fullpp_valid", 32'(pop_valid),  32'd1);
    chk("fullpp_data",  32'(pop_data),   32'hAC);
    drive(0, 8'h00, 0, 0);
    chk("fullpp_occ4",  32'(occupancy), 32'd4);
    chk("fullpp_head",  32'(pop_data),  32'hAD);

    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0);
      chk("rest_data", 32'(pop_data), (i == 0) ? 32'hAD : 32'(8'hB0 + i - 1));
    end
    drive(0, 8'h00, 0, 0);
    chk("rest_occ", 32'(occupancy), 32'd0);

    // Flush with three words held
    drive(1, 8'hC0, 0, 0);
    drive(1, 8'hC1, 0, 0);
    drive(1, 8'hC2, 0, 0);
    drive(1, 8'hC3, 0, 1);
    chk("flush_occ_pre", 32'(occupancy),  32'd3);
    chk("flush_grant",   32'(push_grant), 32'd0);
    chk("flush_valid",   32'(pop_valid),  32'd0);
    drive(0, 8'h00, 0, 0);
    chk("post_flush_occ",    32'(occupancy),    32'd0);
    chk("post_flush_hwm",    32'(hwm),          32'd0);
    chk("post_flush_valid",  32'(pop_valid),    32'd0);
    chk("post_flush_aempty", 32'(almost_empty), 32'd1);

    // Push into empty FIFO with pop_grant asserted
    drive(1, 8'hAB, 1, 0);
`ifdef SYNC_FIFO_BYPASS_EN
    chk("byp_valid", 32'(pop_valid), 32'd1);
    chk("byp_data",  32'(pop_data),  32'hAB);
    drive(0, 8'h00, 0, 0);
    chk("byp_occ",   32'(occupancy), 32'd0);
    chk("byp_hwm",   32'(hwm),       32'd0);
    chk("byp_after", 32'(pop_valid), 32'd0);
`else
    chk("nobyp_valid", 32'(pop_valid), 32'd0);
    drive(0, 8'h00, 0, 0);
    chk("nobyp_occ",   32'(occupancy), 32'd1);
    chk("nobyp_valid1", 32'(pop_valid), 32'd1);
    chk("nobyp_data",  32'(pop_data),  32'hAB);
    chk("nobyp_hwm",   32'(hwm),       32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
